hx8352_init_seq: RTL and testbench

Sequencer that consumes the HX8352 init command ROM and drives the LCD's 8080-style 16-bit parallel write bus.
- After reset, it pulses the panel hardware reset.
- It then walks ROM entries from address 0: writes an index/data pair, executes a microsecond delay, or stops on the done marker.
- It sits between the init ROM and the LCD pins. It releases the bus, with done asserted, for the pixel writer that follows.

---
 rtl/hx8352_pkg.sv | 62 ++++++
 rtl/hx8352_init_seq_if.sv | 22 ++
 rtl/hx8352_bus_writer.sv | 94 +++++++++
 rtl/hx8352_init_seq.sv | 176 +++++++++++++++++
 tb/tb_hx8352_init_seq.sv | 386 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hx8352_pkg.sv
// -----------------------------------------------------------------------------
// hx8352_pkg
// Shared definitions for the HX8352 init sequencer and its command ROM:
//   - custom marker commands (delay / done) embedded in the ROM stream
//   - bit positions of the cmd and value fields inside a 32-bit ROM entry
//   - sequencer and bus-writer state encodings
//   - HX8352 register index constants used when building the init ROM
// -----------------------------------------------------------------------------
package hx8352_pkg;

  // Marker commands; never written to the panel.
  localparam logic [7:0] CMD_CUSTOM_DELAY = 8'hFE;
  localparam logic [7:0] CMD_CUSTOM_DONE  = 8'hFF;

  // ROM entry layout: [31:24] unused, [23:16] cmd, [15:0] value.
  localparam int ENTRY_CMD_MSB = 23;
  localparam int ENTRY_CMD_LSB = 16;
  localparam int ENTRY_VAL_MSB = 15;
  localparam int ENTRY_VAL_LSB = 0;

  // HX8352 register indices referenced by the init ROM.
  localparam logic [7:0] HX_REG_TEST_MODE    = 8'h83;
  localparam logic [7:0] HX_REG_VDDD_CTRL    = 8'h85;
  localparam logic [7:0] HX_REG_SRC_GAMMA    = 8'h8B;
  localparam logic [7:0] HX_REG_SRC_OP       = 8'h8C;
  localparam logic [7:0] HX_REG_SYNC_FUNC    = 8'h91;
  localparam logic [7:0] HX_REG_MEM_ACCESS   = 8'h16;
  localparam logic [7:0] HX_REG_COLMOD       = 8'h17;
  localparam logic [7:0] HX_REG_OSC_CTRL     = 8'h18;
  localparam logic [7:0] HX_REG_POWER_CTRL   = 8'h1B;
  localparam logic [7:0] HX_REG_DISPLAY_CTRL = 8'h28;
  localparam logic [7:0] HX_REG_SRAM_WRITE   = 8'h22;

  typedef enum logic [3:0] {
    ST_RST_LOW,
    ST_RST_WAIT,
    ST_FETCH,
    ST_FETCH_WAIT,
    ST_DECODE,
    ST_DELAY,
    ST_WR_IDX,
    ST_WR_DAT,
    ST_DONE,
    ST_ERROR
  } seq_state_e;

  typedef enum logic [1:0] {
    WP_IDLE,
    WP_SETUP,
    WP_LOW,
    WP_HIGH
  } wr_phase_e;

  function automatic logic [7:0] entry_cmd(input logic [31:0] entry);
    return entry[ENTRY_CMD_MSB:ENTRY_CMD_LSB];
  endfunction

  function automatic logic [15:0] entry_val(input logic [31:0] entry);
    return entry[ENTRY_VAL_MSB:ENTRY_VAL_LSB];
  endfunction

endpackage

// File: rtl/hx8352_init_seq_if.sv
// -----------------------------------------------------------------------------
// hx8352_init_seq_if
// 8080-style 16-bit write bus towards the HX8352 panel.
//   lcd_rst_n : panel hardware reset
//   lcd_cs_n  : chip select
//   lcd_rs    : 0 = index, 1 = data
//   lcd_wr_n  : write strobe, panel latches on rising edge
//   lcd_rd_n  : read strobe (never used, held high)
//   lcd_data  : bus data
// master = sequencer side, slave = panel side.
// -----------------------------------------------------------------------------
interface hx8352_init_seq_if;
  logic        lcd_rst_n;
  logic        lcd_cs_n;
  logic        lcd_rs;
  logic        lcd_wr_n;
  logic        lcd_rd_n;
  logic [15:0] lcd_data;

  modport master (output lcd_rst_n, lcd_cs_n, lcd_rs, lcd_wr_n, lcd_rd_n, lcd_data);
  modport slave  (input  lcd_rst_n, lcd_cs_n, lcd_rs, lcd_wr_n, lcd_rd_n, lcd_data);
endinterface

// File: rtl/hx8352_bus_writer.sv
// -----------------------------------------------------------------------------
// hx8352_bus_writer
// Performs one write strobe: 1 setup cycle (wr_n=1), WR_LOW cycles wr_n=0,
// WR_HIGH cycles wr_n=1 with rs/data held.
//   clk, rst   : clock, synchronous active-high reset
//   i_start    : start a strobe; accepted only while o_ready=1
//   i_rs/i_data: rs level and data for the strobe
//   i_clr      : clear the held data while idle
//   o_ready    : high when idle and during the last high cycle, so the next
//                strobe can follow without a gap
//   o_wr_n/o_rs/o_data : registered bus outputs
// -----------------------------------------------------------------------------
import hx8352_pkg::*;

module hx8352_bus_writer #(
  parameter int WR_LOW  = 2,
  parameter int WR_HIGH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_start,
  input  logic        i_rs,
  input  logic [15:0] i_data,
  input  logic        i_clr,
  output logic        o_ready,
  output logic        o_wr_n,
  output logic        o_rs,
  output logic [15:0] o_data
);

  localparam int MAXW = (WR_LOW > WR_HIGH) ? WR_LOW : WR_HIGH;
  localparam int CW   = $clog2(MAXW + 1);

  wr_phase_e   r_phase;
  logic [CW-1:0] r_cnt;

  logic w_high_last;
  assign w_high_last = (r_phase == WP_HIGH) && (r_cnt == CW'(WR_HIGH - 1));
  assign o_ready     = (r_phase == WP_IDLE) || w_high_last;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values; reset is synchronous, tested inside the clocked block.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_phase <= WP_IDLE;
      r_cnt   <= '0;
      o_wr_n  <= 1'b1;
      o_rs    <= 1'b1;
      o_data  <= '0;
    end else begin
      case (r_phase)
        WP_IDLE: begin
          if (i_start) begin
            r_phase <= WP_SETUP;
            o_rs    <= i_rs;
            o_data  <= i_data;
          end else if (i_clr) begin
            o_data  <= '0;
          end
        end
        WP_SETUP: begin
          o_wr_n  <= 1'b0;
          r_cnt   <= '0;
          r_phase <= WP_LOW;
        end
        WP_LOW: begin
          if (r_cnt == CW'(WR_LOW - 1)) begin
            o_wr_n  <= 1'b1;
            r_cnt   <= '0;
            r_phase <= WP_HIGH;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        WP_HIGH: begin
          if (w_high_last) begin
            // Back-to-back strobe: load the next word straight into setup.
            if (i_start) begin
              r_phase <= WP_SETUP;
              o_rs    <= i_rs;
              o_data  <= i_data;
            end else begin
              r_phase <= WP_IDLE;
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: r_phase <= WP_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/hx8352_init_seq.sv
// -----------------------------------------------------------------------------
// hx8352_init_seq
// Walks the HX8352 init ROM after pulsing the panel hardware reset: writes
// index/data pairs, executes microsecond delays, and stops on the done marker
// (or flags an error after MAX_ENTRIES entries without one).
//   clk, rst  : clock, synchronous active-high reset
//   restart   : rerun from entry 0 (no panel reset); honoured in DONE/ERROR only
//   busy/done/error : status
//   rom_addr  : registered ROM address; rom_data valid one cycle later
//   lcd       : panel write bus (interface, master side)
// -----------------------------------------------------------------------------
import hx8352_pkg::*;

module hx8352_init_seq #(
  parameter int CLK_HZ      = 50_000_000,
  parameter int WR_LOW      = 2,
  parameter int WR_HIGH     = 2,
  parameter int RST_LOW_US  = 1000,
  parameter int RST_WAIT_US = 120,
  parameter int MAX_ENTRIES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        restart,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [7:0]  rom_addr,
  input  logic [31:0] rom_data,
  hx8352_init_seq_if.master lcd
);

  localparam int DIV = CLK_HZ / 1_000_000;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;

  seq_state_e    r_state;
  logic [7:0]    r_ptr;
  logic [PW-1:0] r_presc;
  logic [15:0]   r_us_cnt;
  logic [15:0]   r_value;
  logic          r_lcd_rst_n;
  logic          r_cs_n;

  logic [7:0]  w_cmd;
  logic [15:0] w_val;
  logic        w_unused_hi;
  logic        w_tick, w_last_us, w_at_limit, w_dec_write;
  logic        w_start, w_rs, w_clr, w_ready;
  logic [15:0] w_data;
  logic        w_wr_n, w_bus_rs;
  logic [15:0] w_bus_data;

  assign w_cmd       = entry_cmd(rom_data);
  assign w_val       = entry_val(rom_data);
  assign w_unused_hi = ^rom_data[31:24];

  // One us tick every DIV cycles; the prescaler restarts on each delay entry.
  assign w_tick     = (r_presc == PW'(DIV - 1));
  assign w_last_us  = w_tick && (r_us_cnt == 16'd1);
  assign w_at_limit = (r_ptr == 8'(MAX_ENTRIES));

  // The index strobe is launched from DECODE and the data strobe from the last
  // high cycle of the index strobe, so cs_n covers exactly the two strobes.
  assign w_dec_write = (r_state == ST_DECODE) && !w_at_limit &&
                       (w_cmd != CMD_CUSTOM_DONE) && (w_cmd != CMD_CUSTOM_DELAY);
  assign w_start     = w_dec_write || ((r_state == ST_WR_IDX) && w_ready);
  assign w_rs        = (r_state == ST_WR_IDX);
  assign w_data      = w_rs ? r_value : {8'h00, w_cmd};
  assign w_clr       = (r_state == ST_DECODE) && (w_at_limit || (w_cmd == CMD_CUSTOM_DONE));

  hx8352_bus_writer #(
    .WR_LOW  (WR_LOW),
    .WR_HIGH (WR_HIGH)
  ) u_writer (
    .clk     (clk),
    .rst     (rst),
    .i_start (w_start),
    .i_rs    (w_rs),
    .i_data  (w_data),
    .i_clr   (w_clr),
    .o_ready (w_ready),
    .o_wr_n  (w_wr_n),
    .o_rs    (w_bus_rs),
    .o_data  (w_bus_data)
  );

  assign lcd.lcd_rst_n = r_lcd_rst_n;
  assign lcd.lcd_cs_n  = r_cs_n;
  assign lcd.lcd_rs    = w_bus_rs;
  assign lcd.lcd_wr_n  = w_wr_n;
  assign lcd.lcd_rd_n  = 1'b1;
  assign lcd.lcd_data  = w_bus_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_RST_LOW;
      r_ptr       <= '0;
      r_presc     <= '0;
      r_us_cnt    <= 16'(RST_LOW_US);
      r_value     <= '0;
      r_lcd_rst_n <= 1'b0;
      r_cs_n      <= 1'b1;
      rom_addr    <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
    end else begin
      if (r_state inside {ST_RST_LOW, ST_RST_WAIT, ST_DELAY}) begin
        r_presc <= w_tick ? '0 : r_presc + PW'(1);
        if (w_tick && !w_last_us) r_us_cnt <= r_us_cnt - 16'd1;
      end

      case (r_state)
        ST_RST_LOW: begin
          busy <= 1'b1;
          if (w_last_us) begin
            r_state     <= ST_RST_WAIT;
            r_lcd_rst_n <= 1'b1;
            r_us_cnt    <= 16'(RST_WAIT_US);
          end
        end
        ST_RST_WAIT: if (w_last_us) r_state <= ST_FETCH;
        ST_DELAY:    if (w_last_us) r_state <= ST_FETCH;
        ST_FETCH: begin
          rom_addr <= r_ptr;
          r_state  <= ST_FETCH_WAIT;
        end
        ST_FETCH_WAIT: r_state <= ST_DECODE;
        ST_DECODE: begin
          if (w_at_limit) begin
            r_state <= ST_ERROR;
            error   <= 1'b1;
            busy    <= 1'b0;
          end else if (w_cmd == CMD_CUSTOM_DONE) begin
            r_state <= ST_DONE;
            done    <= 1'b1;
            busy    <= 1'b0;
          end else begin
            r_ptr <= r_ptr + 8'd1;
            if (w_cmd == CMD_CUSTOM_DELAY) begin
              if (w_val == 16'd0) begin
                r_state <= ST_FETCH;
              end else begin
                r_state  <= ST_DELAY;
                r_us_cnt <= w_val;
                r_presc  <= '0;
              end
            end else begin
              r_state <= ST_WR_IDX;
              r_value <= w_val;
              r_cs_n  <= 1'b0;
            end
          end
        end
        ST_WR_IDX: if (w_ready) r_state <= ST_WR_DAT;
        ST_WR_DAT: begin
          if (w_ready) begin
            r_state <= ST_FETCH;
            r_cs_n  <= 1'b1;
          end
        end
        ST_DONE, ST_ERROR: begin
          if (restart) begin
            r_state <= ST_FETCH;
            r_ptr   <= '0;
            done    <= 1'b0;
            error   <= 1'b0;
            busy    <= 1'b1;
          end
        end
        default: r_state <= ST_RST_LOW;
      endcase
    end
  end

endmodule

// File: tb/tb_hx8352_init_seq.sv
// -----------------------------------------------------------------------------
// tb_hx8352_init_seq
// Directed bench for hx8352_init_seq with CLK_HZ=4 MHz (4 cycles/us),
// WR_LOW=2, WR_HIGH=1, RST_LOW_US=2, RST_WAIT_US=1, MAX_ENTRIES=64.
// A negedge monitor records every completed strobe (rising wr_n with cs_n low).
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
import hx8352_pkg::*;

module tb_hx8352_init_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        restart = 1'b0;
  logic        busy, done, error;
  logic [7:0]  rom_addr;
  logic [31:0] rom_data;
  logic [31:0] rom [0:255];

  hx8352_init_seq_if lcd_if ();

  hx8352_init_seq #(
    .CLK_HZ      (4_000_000),
    .WR_LOW      (2),
    .WR_HIGH     (1),
    .RST_LOW_US  (2),
    .RST_WAIT_US (1),
    .MAX_ENTRIES (64)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .restart  (restart),
    .busy     (busy),
    .done     (done),
    .error    (error),
    .rom_addr (rom_addr),
    .rom_data (rom_data),
    .lcd      (lcd_if)
  );

  always #5 clk = ~clk;

  // ROM model with one cycle of read latency.
  always @(posedge clk) rom_data <= rom[rom_addr];

  int n_cmp  = 0;
  int n_fail = 0;

  // Strobe monitor.
  logic        mon_clr = 1'b0;
  int          n_strobes, low_run, cs_run, n_cs_runs, last_cs_run;
  logic        prev_wr_n, wr_low_seen, rst_low_seen;
  logic        st_rs   [0:255];
  logic [15:0] st_data [0:255];
  logic [7:0]  st_low  [0:255];

  always @(negedge clk) begin
    if (mon_clr) begin
      n_strobes <= 0; low_run <= 0; cs_run <= 0; n_cs_runs <= 0; last_cs_run <= 0;
      prev_wr_n <= 1'b1; wr_low_seen <= 1'b0; rst_low_seen <= 1'b0;
    end else begin
      prev_wr_n <= lcd_if.lcd_wr_n;
      if (lcd_if.lcd_wr_n === 1'b0) begin
        low_run     <= low_run + 1;
        wr_low_seen <= 1'b1;
      end else begin
        if (prev_wr_n === 1'b0 && lcd_if.lcd_cs_n === 1'b0 && n_strobes < 256) begin
          st_rs[n_strobes]   <= lcd_if.lcd_rs;
          st_data[n_strobes] <= lcd_if.lcd_data;
          st_low[n_strobes]  <= 8'(low_run);
          n_strobes          <= n_strobes + 1;
        end
        low_run <= 0;
      end
      if (lcd_if.lcd_cs_n === 1'b0) begin
        cs_run <= cs_run + 1;
      end else begin
        if (cs_run != 0) begin
          last_cs_run <= cs_run;
          n_cs_runs   <= n_cs_runs + 1;
        end
        cs_run <= 0;
      end
      if (lcd_if.lcd_rst_n === 1'b0) rst_low_seen <= 1'b1;
    end
  end

  // ---------------------------------------------------------------- helpers
  task automatic load_write_prog();
    for (int i = 0; i < 256; i++) rom[i] = 32'h00FF_0000;
    rom[0] = {8'h00, HX_REG_TEST_MODE, 16'h0002};
    rom[1] = {8'h00, CMD_CUSTOM_DONE, 16'h0000};
  endtask

  // Holds rst for three cycles and leaves it asserted, #1 after a posedge.
  task automatic do_reset();
    rst     = 1'b1;
    mon_clr = 1'b1;
    repeat (3) @(posedge clk);
    #1 mon_clr = 1'b0;
  endtask

  task automatic release_rst();
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic wait_end(input int budget, input string tag);
    int i;
    for (i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done === 1'b1 || error === 1'b1) break;
    end
    n_cmp++;
    if (i >= budget) begin
      n_fail++;
      $display("FAIL %s_timeout: no done/error within %0d cycles (required one)", tag, budget);
    end
  endtask

  task automatic wait_rst_rise();
    int i;
    for (i = 0; i < 200; i++) begin
      @(negedge clk);
      if (lcd_if.lcd_rst_n === 1'b1) break;
    end
    n_cmp++;
    if (i >= 200) begin
      n_fail++;
      $display("FAIL rst_rise_timeout: lcd_rst_n=%b after 200 cycles (required 1)", lcd_if.lcd_rst_n);
    end
  endtask

  // ---------------------------------------------------------------- tests
  task automatic test_reset();
    logic [33:0] obs;
    int n_low, n_pre, busy_bad;
    load_write_prog();
    do_reset();
    @(negedge clk);
    obs = {busy, done, error, rom_addr, lcd_if.lcd_rst_n, lcd_if.lcd_cs_n, lcd_if.lcd_rs,
           lcd_if.lcd_wr_n, lcd_if.lcd_rd_n, lcd_if.lcd_data};
    n_cmp++;
    if (obs !== {3'b000, 8'h00, 5'b01111, 16'h0000}) begin
      n_fail++;
      $display("FAIL reset_values: got %h required %h", obs, {3'b000, 8'h00, 5'b01111, 16'h0000});
    end

    release_rst();
    n_low = 0; busy_bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (lcd_if.lcd_rst_n !== 1'b0) break;
      if (n_low > 0 && busy !== 1'b1) busy_bad++;
      n_low++;
    end
    n_cmp++;
    if (n_low != 8) begin
      n_fail++;
      $display("FAIL rst_low_cycles: got %0d required 8", n_low);
    end
    n_pre = 0;
    for (int i = 0; i < 100; i++) begin
      if (lcd_if.lcd_cs_n !== 1'b1) break;
      if (busy !== 1'b1) busy_bad++;
      n_pre++;
      @(negedge clk);
    end
    // 4 cycles of RST_WAIT, then FETCH, FETCH_WAIT, DECODE.
    n_cmp++;
    if (n_pre != 7) begin
      n_fail++;
      $display("FAIL rst_high_to_cs: got %0d required 7", n_pre);
    end
    n_cmp++;
    if (busy_bad != 0) begin
      n_fail++;
      $display("FAIL busy_during_init: %0d cycles with busy=0 (required 0)", busy_bad);
    end
  endtask

  task automatic test_write();
    logic [74:0] st;
    wait_end(200, "write");
    n_cmp++;
    if ({done, busy, error, rom_addr} !== {3'b100, 8'd1}) begin
      n_fail++;
      $display("FAIL write_status: done/busy/error/addr=%b%b%b/%0d required 100/1",
               done, busy, error, rom_addr);
    end
    st = {8'(n_strobes), st_rs[0], st_data[0], st_low[0], st_rs[1], st_data[1], st_low[1]};
    n_cmp++;
    if (st !== {8'd2, 1'b0, 16'h0083, 8'd2, 1'b1, 16'h0002, 8'd2}) begin
      n_fail++;
      $display("FAIL write_strobes: got %h required %h", st,
               {8'd2, 1'b0, 16'h0083, 8'd2, 1'b1, 16'h0002, 8'd2});
    end
    n_cmp++;
    if (n_cs_runs != 1 || last_cs_run != 8) begin
      n_fail++;
      $display("FAIL write_cs_window: runs=%0d len=%0d required 1/8", n_cs_runs, last_cs_run);
    end
    n_cmp++;
    if ({lcd_if.lcd_cs_n, lcd_if.lcd_wr_n, lcd_if.lcd_rst_n, lcd_if.lcd_data} !== {3'b111, 16'h0000}) begin
      n_fail++;
      $display("FAIL done_bus_idle: cs/wr/rst=%b%b%b data=%h required 111/0000",
               lcd_if.lcd_cs_n, lcd_if.lcd_wr_n, lcd_if.lcd_rst_n, lcd_if.lcd_data);
    end
  endtask

  task automatic test_restart();
    logic [74:0] st;
    int i;
    // Restart from DONE: rerun without a panel reset.
    @(posedge clk);
    #1 restart = 1'b1; mon_clr = 1'b1;
    @(posedge clk);
    #1 restart = 1'b0; mon_clr = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({done, busy} !== 2'b01) begin
      n_fail++;
      $display("FAIL restart_clears: done/busy=%b%b required 01", done, busy);
    end
    wait_end(200, "restart");
    st = {8'(n_strobes), st_rs[0], st_data[0], st_low[0], st_rs[1], st_data[1], st_low[1]};
    n_cmp++;
    if (st !== {8'd2, 1'b0, 16'h0083, 8'd2, 1'b1, 16'h0002, 8'd2} || done !== 1'b1 || rom_addr !== 8'd1) begin
      n_fail++;
      $display("FAIL restart_rerun: strobes=%h done=%b addr=%0d required 2 correct strobes, 1, 1",
               st, done, rom_addr);
    end
    n_cmp++;
    if (rst_low_seen !== 1'b0) begin
      n_fail++;
      $display("FAIL restart_no_panel_reset: lcd_rst_n low seen=%b required 0", rst_low_seen);
    end

    // Restart while busy must be ignored.
    @(posedge clk);
    #1 restart = 1'b1; mon_clr = 1'b1;
    @(posedge clk);
    #1 restart = 1'b0; mon_clr = 1'b0;
    for (i = 0; i < 100; i++) begin
      @(negedge clk);
      if (lcd_if.lcd_cs_n === 1'b0) break;
    end
    @(posedge clk);
    #1 restart = 1'b1;
    @(posedge clk);
    #1 restart = 1'b0;
    wait_end(200, "restart_busy");
    n_cmp++;
    if (n_strobes != 2 || n_cs_runs != 1 || done !== 1'b1 || rom_addr !== 8'd1) begin
      n_fail++;
      $display("FAIL restart_while_busy: strobes=%0d cs_runs=%0d done=%b addr=%0d required 2/1/1/1",
               n_strobes, n_cs_runs, done, rom_addr);
    end
  endtask

  task automatic test_delay();
    int n0, n1;
    for (int i = 0; i < 256; i++) rom[i] = 32'h00FF_0000;
    rom[0] = {8'h00, CMD_CUSTOM_DELAY, 16'h0003};
    rom[1] = {8'h00, CMD_CUSTOM_DELAY, 16'h0000};
    rom[2] = {8'h00, CMD_CUSTOM_DONE,  16'h0000};
    do_reset();
    release_rst();
    wait_rst_rise();
    // RST_WAIT 4 + FETCH + FETCH_WAIT + DECODE + DELAY 12 + FETCH = 20.
    n0 = 0;
    for (int i = 0; i < 200; i++) begin
      if (rom_addr !== 8'd0) break;
      n0++;
      @(negedge clk);
    end
    n1 = 0;
    for (int i = 0; i < 200; i++) begin
      if (rom_addr !== 8'd1) break;
      n1++;
      @(negedge clk);
    end
    n_cmp++;
    if (n0 != 20) begin
      n_fail++;
      $display("FAIL delay_3us_span: got %0d required 20", n0);
    end
    n_cmp++;
    if (n1 != 3) begin
      n_fail++;
      $display("FAIL delay_zero_span: got %0d required 3", n1);
    end
    wait_end(100, "delay");
    n_cmp++;
    if ({done, error, rom_addr} !== {2'b10, 8'd2} || wr_low_seen !== 1'b0 || n_cs_runs != 0) begin
      n_fail++;
      $display("FAIL delay_end: done/error=%b%b addr=%0d wr_low=%b cs_runs=%0d required 10/2/0/0",
               done, error, rom_addr, wr_low_seen, n_cs_runs);
    end
  endtask

  task automatic test_error();
    int bad;
    for (int i = 0; i < 256; i++) rom[i] = 32'h00FF_0000;
    for (int i = 0; i < 64; i++) rom[i] = {8'h00, HX_REG_MEM_ACCESS, 16'h001C};
    do_reset();
    release_rst();
    wait_end(2000, "error");
    bad = 0;
    for (int i = 0; i < 128; i++) begin
      if (i % 2 == 0 && (st_rs[i] !== 1'b0 || st_data[i] !== 16'h0016)) bad++;
      if (i % 2 == 1 && (st_rs[i] !== 1'b1 || st_data[i] !== 16'h001C)) bad++;
      if (st_low[i] !== 8'd2) bad++;
    end
    n_cmp++;
    if (n_strobes != 128 || n_cs_runs != 64) begin
      n_fail++;
      $display("FAIL error_pair_count: strobes=%0d cs_runs=%0d required 128/64", n_strobes, n_cs_runs);
    end
    n_cmp++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL error_strobe_content: %0d bad strobes required 0", bad);
    end
    n_cmp++;
    if ({error, done, busy, rom_addr, lcd_if.lcd_cs_n, lcd_if.lcd_wr_n, lcd_if.lcd_rst_n} !==
        {3'b100, 8'd64, 3'b111}) begin
      n_fail++;
      $display("FAIL error_status: err/done/busy=%b%b%b addr=%0d cs/wr/rst=%b%b%b required 100/64/111",
               error, done, busy, rom_addr, lcd_if.lcd_cs_n, lcd_if.lcd_wr_n, lcd_if.lcd_rst_n);
    end
  endtask

  task automatic test_reset_mid_write();
    logic [74:0] st;
    int i;
    load_write_prog();
    do_reset();
    release_rst();
    for (i = 0; i < 300; i++) begin
      @(negedge clk);
      if (lcd_if.lcd_wr_n === 1'b0 && lcd_if.lcd_rs === 1'b1 && lcd_if.lcd_cs_n === 1'b0) break;
    end
    n_cmp++;
    if (i >= 300) begin
      n_fail++;
      $display("FAIL midwrite_reach: data low phase not seen in 300 cycles (required seen)");
    end
    rst = 1'b1;
    @(negedge clk);
    #1;
    n_cmp++;
    if ({lcd_if.lcd_wr_n, lcd_if.lcd_cs_n, lcd_if.lcd_rst_n, busy, rom_addr} !== {4'b1100, 8'd0}) begin
      n_fail++;
      $display("FAIL midwrite_abort: wr/cs/rst/busy=%b%b%b%b addr=%0d required 1100/0",
               lcd_if.lcd_wr_n, lcd_if.lcd_cs_n, lcd_if.lcd_rst_n, busy, rom_addr);
    end
    n_cmp++;
    if (n_strobes != 1) begin
      n_fail++;
      $display("FAIL midwrite_no_completion: strobes=%0d required 1", n_strobes);
    end
    do_reset();
    release_rst();
    wait_end(300, "midwrite_rerun");
    st = {8'(n_strobes), st_rs[0], st_data[0], st_low[0], st_rs[1], st_data[1], st_low[1]};
    n_cmp++;
    if (st !== {8'd2, 1'b0, 16'h0083, 8'd2, 1'b1, 16'h0002, 8'd2} || done !== 1'b1 || rom_addr !== 8'd1) begin
      n_fail++;
      $display("FAIL midwrite_rerun: strobes=%h done=%b addr=%0d required 2 correct strobes, 1, 1",
               st, done, rom_addr);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_restart();
    test_delay();
    test_error();
    test_reset_mid_write();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
